pkt_arbiter: RTL and testbench

- Merges the packet streams of NUM_PIPES parallel pkt_assembler instances (one per event pipe) onto the single SpiNNaker multicast packet output.
- Grants one input per cycle under round-robin.
- Registered output stage with a one-entry park register, so a packet can be accepted every cycle while downstream is ready.
- Keeps per-pipe saturating packet counters for the register bank.

---
 rtl/pkt_arbiter_if.sv | 25 ++
 rtl/pkt_arbiter.sv | 111 +++++++++++
 tb/tb_pkt_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pkt_arbiter_if.sv
// Packet merge bus: NUM_PIPES assembler streams in, one multicast stream out,
// plus the per-pipe packet counters exported to the register bank.
interface pkt_arbiter_if #(
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned PKT_BITS  = 72
);
  logic [NUM_PIPES-1:0][PKT_BITS-1:0] pkt_data_in;
  logic [NUM_PIPES-1:0]               pkt_vld_in;
  logic [NUM_PIPES-1:0]               pkt_rdy_out;
  logic [PKT_BITS-1:0]                pkt_data_out;
  logic                               pkt_vld_out;
  logic                               pkt_rdy_in;
  logic                               cnt_clr_in;
  logic [NUM_PIPES-1:0][31:0]         pkt_cnt_out;

  modport slave (
    input  pkt_data_in, pkt_vld_in, pkt_rdy_in, cnt_clr_in,
    output pkt_rdy_out, pkt_data_out, pkt_vld_out, pkt_cnt_out
  );

  modport master (
    output pkt_data_in, pkt_vld_in, pkt_rdy_in, cnt_clr_in,
    input  pkt_rdy_out, pkt_data_out, pkt_vld_out, pkt_cnt_out
  );
endinterface

// File: rtl/pkt_arbiter.sv
// Round-robin merge of NUM_PIPES packet streams onto one registered output with a
// single park slot, so one packet per cycle flows while downstream is ready.
module pkt_arbiter #(
  parameter int unsigned NUM_PIPES = 4,
  parameter int unsigned PKT_BITS  = 72
) (
  input logic          clk,
  input logic          reset,
  pkt_arbiter_if.slave bus
);
  localparam int unsigned IdxW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic [IdxW-1:0]            rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]            gnt_idx;
  logic [IdxW:0]              cand;
  logic                       gnt_found;
  logic                       xfer;
  logic                       busy;
  logic                       rdy_en_q;
  logic                       vld_q, vld_d;
  logic [PKT_BITS-1:0]        data_q, data_d;
  logic                       parked_q, parked_d;
  logic [PKT_BITS-1:0]        park_data_q, park_data_d;
  logic [NUM_PIPES-1:0][31:0] cnt_q, cnt_d;
  logic [NUM_PIPES-1:0]       rdy;

  // First valid input after the last grant, wrapping modulo NUM_PIPES.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_PIPES; off++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(off);
      if (cand >= (IdxW + 1)'(NUM_PIPES)) begin
        cand = cand - (IdxW + 1)'(NUM_PIPES);
      end
      if (!gnt_found && bus.pkt_vld_in[cand[IdxW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign xfer = gnt_found && rdy_en_q && !parked_q;
  assign busy = vld_q && !bus.pkt_rdy_in;

  always_comb begin
    rdy = '0;
    if (xfer) begin
      rdy[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    vld_d       = busy || parked_q || xfer;
    data_d      = data_q;
    park_data_d = park_data_q;
    parked_d    = parked_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = gnt_idx;
      if (busy) begin
        park_data_d = bus.pkt_data_in[gnt_idx];
        parked_d    = 1'b1;
      end else begin
        data_d = bus.pkt_data_in[gnt_idx];
      end
    end else if (parked_q && bus.pkt_rdy_in) begin
      data_d   = park_data_q;
      parked_d = 1'b0;
    end
  end

  // Saturating counters; clear takes precedence over a coincident accept.
  always_comb begin
    for (int unsigned i = 0; i < NUM_PIPES; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.cnt_clr_in) begin
        cnt_d[i] = '0;
      end else if (xfer && (gnt_idx == IdxW'(i)) && (cnt_q[i] != 32'hFFFF_FFFF)) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= IdxW'(NUM_PIPES - 1);
      rdy_en_q    <= 1'b0;
      vld_q       <= 1'b0;
      data_q      <= '0;
      parked_q    <= 1'b0;
      park_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rdy_en_q    <= 1'b1;
      vld_q       <= vld_d;
      data_q      <= data_d;
      parked_q    <= parked_d;
      park_data_q <= park_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.pkt_rdy_out  = rdy;
  assign bus.pkt_vld_out  = vld_q;
  assign bus.pkt_data_out = data_q;
  assign bus.pkt_cnt_out  = cnt_q;

endmodule

// File: tb/tb_pkt_arbiter.sv
// Directed and randomised checks of pkt_arbiter against a queue-based model:
// the output stage is a 2-deep FIFO and grants follow round-robin order.
module tb_pkt_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned PB = 72;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pkt_arbiter_if #(.NUM_PIPES(N), .PKT_BITS(PB)) bus ();

  pkt_arbiter #(.NUM_PIPES(N), .PKT_BITS(PB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [PB-1:0]  m_q[$];
  int unsigned    m_last;
  bit             m_en;
  logic [31:0]    m_cnt[N];
  int unsigned    seq[N];
  logic [N-1:0]   obs_rdy;
  logic [PB-1:0]  emitted[$];

  function automatic logic [PB-1:0] mk_pkt(input int unsigned pipe, input int unsigned s);
    logic [31:0] h;
    h = s * 32'h9E37_79B1;
    return {h, s, pipe[7:0]};
  endfunction

  function automatic logic [N*32-1:0] exp_cnt();
    logic [N*32-1:0] r;
    for (int i = 0; i < N; i++) r[i*32 +: 32] = m_cnt[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last = N - 1;
    m_en   = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = '0;
  endtask

  // Called just after a falling edge; returns after the next falling edge.
  task automatic cycle(input logic [N-1:0] v, input logic r, input logic c);
    int unsigned  g;
    bit           found;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) bus.pkt_data_in[i] = mk_pkt(i, seq[i]);
    bus.pkt_vld_in = v;
    bus.pkt_rdy_in = r;
    bus.cnt_clr_in = c;
    #1;
    found = 1'b0;
    g     = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      int unsigned idx;
      idx = (m_last + off) % N;
      if (!found && v[idx]) begin
        found = 1'b1;
        g     = idx;
      end
    end
    exp_rdy = '0;
    if (found && m_en && m_q.size() < 2) exp_rdy[g] = 1'b1;
    obs_rdy = bus.pkt_rdy_out;
    check("rdy_out", 128'(obs_rdy), 128'(exp_rdy));
    check("rdy_onehot", 128'($countones(obs_rdy) <= 1), 128'(1));
    check("vld_out", 128'(bus.pkt_vld_out), 128'(m_q.size() > 0));
    if (m_q.size() > 0) check("data_out", 128'(bus.pkt_data_out), 128'(m_q[0]));
    check("cnt_out", 128'(bus.pkt_cnt_out), 128'(exp_cnt()));
    if (bus.pkt_vld_out && r) emitted.push_back(bus.pkt_data_out);
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (m_q.size() > 0 && r) void'(m_q.pop_front());
      if (exp_rdy != '0) begin
        m_q.push_back(mk_pkt(g, seq[g]));
        m_last = g;
        seq[g]++;
      end
      for (int i = 0; i < N; i++) begin
        if (c) m_cnt[i] = '0;
        else if (exp_rdy[i] && m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
      end
      m_en = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] t1_exp[6];
    int unsigned  s0;
    logic [N-1:0] v;
    logic         r;
    logic         c;
    t1_exp = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < N; i++) seq[i] = 0;
    model_reset();
    bus.pkt_vld_in = '1;
    bus.pkt_rdy_in = 1'b1;
    bus.cnt_clr_in = 1'b0;
    for (int i = 0; i < N; i++) bus.pkt_data_in[i] = mk_pkt(i, 0);

    // Reset state
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_vld", 128'(bus.pkt_vld_out), 128'(0));
    check("rst_data", 128'(bus.pkt_data_out), 128'(0));
    check("rst_rdy", 128'(bus.pkt_rdy_out), 128'(0));
    check("rst_cnt", 128'(bus.pkt_cnt_out), 128'(0));
    cycle(4'b1111, 1'b1, 1'b0);
    reset = 1'b1;

    // All valid: first cycle idle, then grants rotate 0,1,2,3,0
    for (int k = 0; k < 6; k++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      check("t1_grant", 128'(obs_rdy), 128'(t1_exp[k]));
      if (k == 1) check("t1_latency", 128'(bus.pkt_data_out), 128'(mk_pkt(0, 0)));
      if (k == 4) check("t1_cnt", 128'(bus.pkt_cnt_out), {4{32'd1}});
    end

    // Only pipes 1 and 3 valid: alternate
    cycle(4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1010, 1'b1, 1'b0);
      check("t2_grant", 128'(obs_rdy), (k % 2 == 0) ? 128'(4'b0010) : 128'(4'b1000));
    end
    check("t2_cnt", 128'(bus.pkt_cnt_out), {32'd4, 32'd0, 32'd4, 32'd0});

    // Downstream stall while pipe 2 streams A, B, C
    cycle(4'b0000, 1'b1, 1'b0);
    emitted.delete();
    s0 = seq[2];
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      if (k >= 2) check("t3_rdy_stalled", 128'(obs_rdy), 128'(0));
      check("t3_hold_data", 128'(bus.pkt_data_out), 128'(mk_pkt(2, s0)));
      check("t3_hold_vld", 128'(bus.pkt_vld_out), 128'(1));
    end
    for (int k = 0; k < 4; k++) cycle((k < 2) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
    check("t3_count", 128'(emitted.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      check("t3_order", (i < emitted.size()) ? 128'(emitted[i]) : 128'(0),
            128'(mk_pkt(2, s0 + i)));
    end

    // Counter saturation, then clear beating a coincident accept
    cycle(4'b0000, 1'b1, 1'b1);
    force dut.cnt_q = {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFE};
    m_cnt[0] = 32'hFFFF_FFFE;
    cycle(4'b0000, 1'b1, 1'b0);
    release dut.cnt_q;
    for (int k = 0; k < 3; k++) cycle(4'b0001, 1'b1, 1'b0);
    check("t4_saturate", 128'(bus.pkt_cnt_out), {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF});
    cycle(4'b0001, 1'b1, 1'b1);
    check("t4_clr_accept", 128'(obs_rdy), 128'(4'b0001));
    check("t4_clr_wins", 128'(bus.pkt_cnt_out), 128'(0));

    // Asynchronous reset while a packet is parked
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check("t5_vld_async", 128'(bus.pkt_vld_out), 128'(0));
    check("t5_rdy_async", 128'(bus.pkt_rdy_out), 128'(0));
    model_reset();
    cycle(4'b0001, 1'b0, 1'b0);
    reset = 1'b1;
    cycle(4'b1111, 1'b1, 1'b0);
    check("t5_first_idle", 128'(obs_rdy), 128'(0));
    cycle(4'b1111, 1'b1, 1'b0);
    check("t5_first_grant", 128'(obs_rdy), 128'(4'b0001));

    // Randomised valid/ready/clear
    for (int k = 0; k < 10000; k++) begin
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(0, 9) < 6);
      r = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 299) == 0);
      cycle(v, r, c);
    end
    for (int k = 0; k < 4; k++) cycle(4'b0000, 1'b1, 1'b0);
    check("drain_empty", 128'(bus.pkt_vld_out), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
